muldiv_unit: RTL and testbench
==============================

// Module: muldiv_unit
// PURPOSE
//  Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS core.
//  Sits beside the ALU and executes MULT/MULTU/DIV/DIVU, with operands taken from regfile rs/rt.
//  The core controller stalls on busy. MFHI/MFLO read hi/lo directly; MTHI/MTLO write them.
// PARAMETERS
//  WIDTH  32  operand width; the product is 2*WIDTH bits; one iteration is done per clock.
// PORTS
//  clk      in   1      system clock, rising edge
//  rst_n    in   1      asynchronous active-low reset
//  start    in   1      launch op; sampled only in IDLE
//  op       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//  a        in   WIDTH  rs operand (multiplicand / dividend)
//  b        in   WIDTH  rt operand (multiplier / divisor)
//  mthi_we  in   1      write wdata to hi (MTHI)
//  mtlo_we  in   1      write wdata to lo (MTLO)
//  wdata    in   WIDTH  MTHI/MTLO data
//  busy     out  1      an operation is in flight (state != IDLE)
//  done     out  1      one-cycle pulse: hi/lo hold the new result
//  hi       out  WIDTH  HI register (product upper half / remainder)
//  lo       out  WIDTH  LO register (product lower half / quotient)
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, counter=0.
//    A reset mid-operation aborts it; no partial result survives.
//  FSM states: IDLE -> RUN -> FIXUP -> IDLE.
//  IDLE: start=1 latches a, b and op, clears the accumulator and counter, goes to RUN.
//  RUN: one shift-add (multiply) or restoring shift-subtract (divide) step per clock.
//    Goes to FIXUP after exactly WIDTH steps.
//  FIXUP: applies sign correction and writes hi/lo, sets done=1 and returns to IDLE.
//  Latency: done is high in the cycle after the (WIDTH+1)th edge following the start-sampling edge,
//    i.e. 33 edges for WIDTH=32. busy is low in that same cycle, and done is low otherwise.
//  Back-to-back: start is accepted in the done cycle.
//  start while busy: ignored. op, a and b are don't-care outside the start cycle.
//  mthi_we/mtlo_we while busy: ignored.
//  mthi_we/mtlo_we in IDLE: the write lands at the next edge.
//    If start is asserted in the same cycle, the write still lands, and the operation result overwrites it later.
//  Divide by zero: lo = all ones, hi = a. Normal latency, no exception.
//  Signed divide: the quotient truncates toward zero and the remainder takes the sign of the dividend.
//    Overflow case MIN/-1: lo = MIN, hi = 0.
//  Signed multiply: full 2*WIDTH-bit two's-complement product.
// CONFIGURATION
//  SIGNED_MULDIV_EN defined: op[0] selects signed operation.
//    Operands are converted to magnitudes before RUN; the results are negated in FIXUP.
//  SIGNED_MULDIV_EN undefined: op[0] is ignored, so MULT acts as MULTU and DIV acts as DIVU.
//    No sign-fixup logic is built, and FIXUP still takes 1 cycle, so latency is unchanged.
// STRUCTURE
//  Shared package muldiv_pkg holds:
//    the op encodings (MD_MULTU, MD_MULT, MD_DIVU, MD_DIV);
//    the FSM state encoding (MD_IDLE, MD_RUN, MD_FIXUP);
//    the counter width, $clog2(WIDTH)+1.
//  Sub-module muldiv_negate: combinational conditional two's-complement negate.
//    It is instantiated only under SIGNED_MULDIV_EN.
//  The FSM, counter and accumulator remain in muldiv_unit.
// TESTING
//  1 MULTU a=FFFFFFFF, b=FFFFFFFF -> hi=FFFFFFFE, lo=00000001.
//    done occurs exactly 33 edges after the start edge; busy is high throughout.
//  2 MULT a=FFFFFFFD (-3), b=7 -> hi=FFFFFFFF, lo=FFFFFFEB. Without the macro: hi=6, lo=FFFFFFEB.
//  3 DIVU a=100, b=7 -> lo=14, hi=2. Then DIV a=-7, b=2 -> lo=FFFFFFFD, hi=FFFFFFFF.
//    The second start is issued in the done cycle.
//  4 DIVU a=1234, b=0 -> lo=FFFFFFFF, hi=1234. DIV a=80000000, b=FFFFFFFF -> lo=80000000, hi=0.
//  5 Start MULTU, pulse start and mthi_we at RUN step 5 -> both are ignored.
//    Drop rst_n at step 10 -> busy, done, hi and lo are 0 immediately, and no done follows.
//  6 Idle MTLO wdata=CAFEF00D -> lo=CAFEF00D next cycle.
//    MTHI combined with start (MULTU 2*3) -> hi=wdata for the run, then hi=0 and lo=6 at done.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states, counter sizing.
// No logic; no latency. No backpressure.
// Imported by muldiv_unit.
package muldiv_pkg;

    localparam logic [1:0] MD_MULTU = 2'b00;
    localparam logic [1:0] MD_MULT  = 2'b01;
    localparam logic [1:0] MD_DIVU  = 2'b10;
    localparam logic [1:0] MD_DIV   = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE  = 2'd0,
        MD_RUN   = 2'd1,
        MD_FIXUP = 2'd2
    } md_state_t;

    localparam int MD_WIDTH = 32;

    // Must hold WIDTH-1 with room to spare, so it never wraps inside RUN.
    function automatic int md_cnt_w(input int width);
        return $clog2(width) + 1;
    endfunction

    localparam int MD_CNT_W = md_cnt_w(MD_WIDTH);

endpackage

// File: rtl/muldiv_negate.sv
// Conditional two's-complement negate; used for operand magnitudes and result sign fixup.
// Purely combinational, zero latency.
// No backpressure.
module muldiv_negate #(
    parameter int W = 32
) (
    input  logic         en,
    input  logic [W-1:0] x,
    output logic [W-1:0] y
);

    assign y = en ? (~x + 1'b1) : x;

endmodule

// File: rtl/muldiv_unit.sv
// MIPS HI/LO multiply/divide unit, one shift-add / restoring shift-subtract step per clock.
// Latency WIDTH+1 edges from the start edge to the done cycle; SIGNED_MULDIV_EN enables signed ops.
// No backpressure: the core stalls on busy; start and MTHI/MTLO are ignored while busy.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mthi_we,
    input  logic             mtlo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = md_cnt_w(WIDTH);

    md_state_t          state;
    logic [CNT_W-1:0]   cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   opnd;
    logic               is_div;

    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [2*WIDTH-1:0] res;

`ifdef SIGNED_MULDIV_EN
    logic               neg_hi;
    logic               neg_lo;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   hi_fix;
    logic [WIDTH-1:0]   lo_fix;

    muldiv_negate #(.W(WIDTH))   u_neg_a   (.en(op[0] & a[WIDTH-1]), .x(a), .y(a_in));
    muldiv_negate #(.W(WIDTH))   u_neg_b   (.en(op[0] & b[WIDTH-1]), .x(b), .y(b_in));
    muldiv_negate #(.W(2*WIDTH)) u_neg_prd (.en(neg_lo), .x(acc), .y(prod_fix));
    muldiv_negate #(.W(WIDTH))   u_neg_hi  (.en(neg_hi), .x(acc[2*WIDTH-1:WIDTH]), .y(hi_fix));
    muldiv_negate #(.W(WIDTH))   u_neg_lo  (.en(neg_lo), .x(acc[WIDTH-1:0]), .y(lo_fix));

    assign res = is_div ? {hi_fix, lo_fix} : prod_fix;
`else
    logic unused_op0;
    assign unused_op0 = op[0];
    assign a_in       = a;
    assign b_in       = b;
    assign res        = acc;
`endif

    // Multiply: acc = {partial product, remaining multiplier bits}.
    // Divide:   acc = {partial remainder, dividend bits shifting into quotient}.
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_rem;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] step_nxt;

    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : {(WIDTH+1){1'b0}});
        div_rem  = acc[2*WIDTH-1:WIDTH-1];
        div_diff = div_rem - {1'b0, opnd};
        step_nxt = {mul_sum, acc[WIDTH-1:1]};
        if (is_div) begin
            if (div_diff[WIDTH])
                step_nxt = {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            else
                step_nxt = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        end
    end

    assign busy = (state != MD_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= MD_IDLE;
            cnt    <= '0;
            acc    <= '0;
            opnd   <= '0;
            is_div <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
`ifdef SIGNED_MULDIV_EN
            neg_hi <= 1'b0;
            neg_lo <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                MD_IDLE: begin
                    if (mthi_we) hi <= wdata;
                    if (mtlo_we) lo <= wdata;
                    if (start) begin
                        acc    <= {{WIDTH{1'b0}}, a_in};
                        opnd   <= b_in;
                        is_div <= op[1];
                        cnt    <= '0;
                        state  <= MD_RUN;
`ifdef SIGNED_MULDIV_EN
                        // Divide by zero keeps quotient all ones; remainder follows the dividend.
                        neg_hi <= op[0] & (op[1] ? a[WIDTH-1] : (a[WIDTH-1] ^ b[WIDTH-1]));
                        neg_lo <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]) & (!op[1] || (b != '0));
`endif
                    end
                end
                MD_RUN: begin
                    acc <= step_nxt;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_W'(WIDTH-1)) state <= MD_FIXUP;
                end
                MD_FIXUP: begin
                    {hi, lo} <= res;
                    done     <= 1'b1;
                    state    <= MD_IDLE;
                end
                default: state <= MD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed-vector bench for muldiv_unit: latency, MULT/DIV results, corner cases, MTHI/MTLO, abort.
// Expected values are hand-computed; signed expectations depend on SIGNED_MULDIV_EN.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        mthi_we;
    logic        mtlo_we;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int vectors;
    int miscompares;

    muldiv_unit #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op(op), .a(a), .b(b),
        .mthi_we(mthi_we), .mtlo_we(mtlo_we), .wdata(wdata),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Start is sampled at the posedge following the negedge it is raised on.
    task automatic launch(input logic [1:0] op_i, input logic [31:0] a_i, input logic [31:0] b_i);
        @(negedge clk);
        start = 1'b1; op = op_i; a = a_i; b = b_i;
        @(posedge clk);
        #1;
        start = 1'b0; op = 2'b00; a = '0; b = '0;
    endtask

    task automatic wait_done(output int edges, output logic busy_ok);
        edges   = 0;
        busy_ok = 1'b1;
        do begin
            @(posedge clk);
            #1;
            edges++;
            if (!done && !busy) busy_ok = 1'b0;
        end while (!done && edges < 40);
    endtask

    int   edges;
    logic bok;

    initial begin
        vectors = 0; miscompares = 0;
        rst_n = 1'b0; start = 1'b0; op = 2'b00; a = '0; b = '0;
        mthi_we = 1'b0; mtlo_we = 1'b0; wdata = '0;

        #12;
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // MULTU max*max, latency and busy profile
        launch(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(edges, bok);
        check("multu_latency", 64'(edges), 64'd33);
        check("multu_busy_run", 64'(bok), 64'd1);
        check("multu_busy_done", 64'(busy), 64'd0);
        check("multu_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
        @(posedge clk); #1;
        check("done_pulse_width", 64'(done), 64'd0);

        // MULT -3 * 7
        launch(MD_MULT, 32'hFFFF_FFFD, 32'd7);
        wait_done(edges, bok);
`ifdef SIGNED_MULDIV_EN
        check("mult_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
`else
        check("mult_neg", {hi, lo}, 64'h0000_0006_FFFF_FFEB);
`endif

        // DIVU 100/7, then DIV -7/2 started in the done cycle
        launch(MD_DIVU, 32'd100, 32'd7);
        wait_done(edges, bok);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);
        launch(MD_DIV, 32'hFFFF_FFF9, 32'd2);
        wait_done(edges, bok);
        check("b2b_latency", 64'(edges), 64'd33);
`ifdef SIGNED_MULDIV_EN
        check("div_neg", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
`else
        check("div_neg", {hi, lo}, 64'h0000_0001_7FFF_FFFC);
`endif

        // Divide by zero and signed overflow
        launch(MD_DIVU, 32'd1234, 32'd0);
        wait_done(edges, bok);
        check("div0_latency", 64'(edges), 64'd33);
        check("div0", {hi, lo}, {32'd1234, 32'hFFFF_FFFF});
        launch(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(edges, bok);
`ifdef SIGNED_MULDIV_EN
        check("div_ovf", {hi, lo}, 64'h0000_0000_8000_0000);
`else
        check("div_ovf", {hi, lo}, 64'h8000_0000_0000_0000);
`endif

        // Idle MTLO / MTHI
        @(negedge clk);
        mtlo_we = 1'b1; wdata = 32'hCAFE_F00D;
        @(posedge clk); #1;
        mtlo_we = 1'b0;
        check("mtlo_idle", 64'(lo), 64'hCAFE_F00D);
        @(negedge clk);
        mthi_we = 1'b1; wdata = 32'h1234_5678;
        @(posedge clk); #1;
        mthi_we = 1'b0;
        check("mthi_idle", 64'(hi), 64'h1234_5678);

        // Start + MTHI during RUN are ignored; reset mid-run aborts
        launch(MD_MULTU, 32'd3, 32'd5);
        repeat (4) @(posedge clk);
        @(negedge clk);
        start = 1'b1; op = MD_DIVU; a = 32'd9; b = 32'd3; mthi_we = 1'b1; wdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        start = 1'b0; mthi_we = 1'b0;
        check("mthi_busy_ignored", 64'(hi), 64'h1234_5678);
        check("start_busy_ignored", 64'(busy), 64'd1);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("abort_outputs", {61'd0, busy, done, |{hi, lo}}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_done(edges, bok);
        check("abort_no_done", 64'(done), 64'd0);
        check("abort_idle", 64'(busy), 64'd0);

        // MTHI together with start: write lands, then result overwrites
        @(negedge clk);
        start = 1'b1; op = MD_MULTU; a = 32'd2; b = 32'd3; mthi_we = 1'b1; wdata = 32'hA5A5_A5A5;
        @(posedge clk); #1;
        start = 1'b0; mthi_we = 1'b0;
        check("mthi_with_start", 64'(hi), 64'hA5A5_A5A5);
        wait_done(edges, bok);
        check("mthi_start_latency", 64'(edges), 64'd33);
        check("mthi_start_result", {hi, lo}, 64'h0000_0000_0000_0006);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
